pulse_safety_monitor: RTL

Enforces the laser pulse-width and repetition-rate limits held in the I2C register bank on the incoming trigger stream. It gates `trig_in` into `laser_en`, latches fault causes, and reports status back to the register bank's `monitor_status` read address. It sits between the trigger source and the laser driver. Limits and control bits come straight from the register bank outputs.

---
 rtl/pulse_safety_monitor.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/pulse_safety_monitor.sv
// Laser trigger gate: enforces pulse-width and repetition-rate limits on trig_in,
// latches fault causes and reports a status byte plus last accepted width/period.
module pulse_safety_monitor #(
    parameter int unsigned TICK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        trig_in,
    input  logic [31:0] pulse_width_lower_limit,
    input  logic [31:0] pulse_width_upper_limit,
    input  logic [31:0] rate_lower_limit,
    input  logic        arm,
    input  logic        clear_fault,
    output logic        laser_en,
    output logic        fault,
    output logic [7:0]  monitor_status,
    output logic [31:0] last_width,
    output logic [31:0] last_period,
    output logic [15:0] pulse_count
);

    localparam int unsigned      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_LOW = 3'd1,
        ST_READY    = 3'd2,
        ST_PULSE    = 3'd3,
        ST_GAP      = 3'd4,
        ST_FAULT    = 3'd5
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t            state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic              trig_prev_q;
    logic [31:0]       width_cnt_q, width_cnt_d;
    logic [31:0]       period_cnt_q, period_cnt_d;
    logic [31:0]       last_width_q, last_width_d;
    logic [31:0]       last_period_q, last_period_d;
    logic [15:0]       pulse_count_q, pulse_count_d;
    logic              ovw_q, ovw_d;
    logic              udw_q, udw_d;
    logic              rate_q, rate_d;
    logic              laser_en_q, laser_en_d;
    logic              fault_q, fault_d;
    logic [7:0]        status_q, status_d;
    logic              tick_s;
    logic              rise_s;
    logic              fall_s;

    // Measurement tick divider and trigger edge detection
    always_comb begin
        tick_s = (div_q == DIV_LAST);
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
        rise_s = trig_in & ~trig_prev_q;
        fall_s = ~trig_in & trig_prev_q;
    end

    // Next-state, counter and latch logic; arm=0 overrides everything except FAULT
    always_comb begin
        state_d       = state_q;
        width_cnt_d   = width_cnt_q;
        period_cnt_d  = period_cnt_q;
        last_width_d  = last_width_q;
        last_period_d = last_period_q;
        pulse_count_d = pulse_count_q;
        ovw_d         = ovw_q;
        udw_d         = udw_q;
        rate_d        = rate_q;

        if (tick_s && (state_q == ST_PULSE)) begin
            width_cnt_d = sat_inc(width_cnt_q);
        end else begin
            width_cnt_d = width_cnt_q;
        end
        if (tick_s && ((state_q == ST_PULSE) || (state_q == ST_GAP))) begin
            period_cnt_d = sat_inc(period_cnt_q);
        end else begin
            period_cnt_d = period_cnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    state_d = ST_WAIT_LOW;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_LOW: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (!trig_in) begin
                    state_d = ST_READY;
                end else begin
                    state_d = ST_WAIT_LOW;
                end
            end
            ST_READY: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (rise_s) begin
                    state_d      = ST_PULSE;
                    width_cnt_d  = 32'd0;
                    period_cnt_d = 32'd0;
                end else begin
                    state_d = ST_READY;
                end
            end
            ST_PULSE: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (width_cnt_q >= pulse_width_upper_limit) begin
                    state_d = ST_FAULT;
                    ovw_d   = 1'b1;
                end else if (fall_s) begin
                    if (width_cnt_q < pulse_width_lower_limit) begin
                        state_d = ST_FAULT;
                        udw_d   = 1'b1;
                    end else begin
                        state_d       = ST_GAP;
                        last_width_d  = width_cnt_q;
                        pulse_count_d = pulse_count_q + 16'd1;
                    end
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_GAP: begin
                if (!arm) begin
                    state_d = ST_IDLE;
                end else if (rise_s) begin
                    if ((rate_lower_limit != 32'd0) && (period_cnt_q < rate_lower_limit)) begin
                        state_d = ST_FAULT;
                        rate_d  = 1'b1;
                    end else begin
                        state_d       = ST_PULSE;
                        last_period_d = period_cnt_q;
                        width_cnt_d   = 32'd0;
                        period_cnt_d  = 32'd0;
                    end
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_FAULT: begin
                // A clear while the trigger is still high would re-enable mid-pulse
                if (clear_fault && !trig_in) begin
                    ovw_d  = 1'b0;
                    udw_d  = 1'b0;
                    rate_d = 1'b0;
                    if (arm) begin
                        state_d = ST_WAIT_LOW;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        laser_en_d = (state_d == ST_PULSE);
        fault_d    = (state_d == ST_FAULT);
        status_d   = {1'b0, trig_in, rate_d, udw_d, ovw_d, fault_d, laser_en_d,
                      (state_d != ST_IDLE) && (state_d != ST_FAULT)};
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            trig_prev_q   <= 1'b0;
            width_cnt_q   <= 32'd0;
            period_cnt_q  <= 32'd0;
            last_width_q  <= 32'd0;
            last_period_q <= 32'd0;
            pulse_count_q <= 16'd0;
            ovw_q         <= 1'b0;
            udw_q         <= 1'b0;
            rate_q        <= 1'b0;
            laser_en_q    <= 1'b0;
            fault_q       <= 1'b0;
            status_q      <= 8'd0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            trig_prev_q   <= trig_in;
            width_cnt_q   <= width_cnt_d;
            period_cnt_q  <= period_cnt_d;
            last_width_q  <= last_width_d;
            last_period_q <= last_period_d;
            pulse_count_q <= pulse_count_d;
            ovw_q         <= ovw_d;
            udw_q         <= udw_d;
            rate_q        <= rate_d;
            laser_en_q    <= laser_en_d;
            fault_q       <= fault_d;
            status_q      <= status_d;
        end
    end

    assign laser_en       = laser_en_q;
    assign fault          = fault_q;
    assign monitor_status = status_q;
    assign last_width     = last_width_q;
    assign last_period    = last_period_q;
    assign pulse_count    = pulse_count_q;

endmodule
